// File: rtl/best_t.sv
// best_t -- inverse d/u selector search.
//
// Given a code length n and a target log2(d) u, finds the smallest error
// count t in 1..18 whose q(t) = (n*theta(t)) >> 5 maps to u_of(q) <= u.
// Each candidate is a 5-cycle LSB-first shift-add multiply (MUL) followed
// by a 1-cycle compare (CMP), so a search costs 6 cycles per candidate.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request pulse, sampled only in IDLE
//   n      in   13-bit code length (0..4900), latched on accepted start
//   u      in   4-bit target log2(d), latched on accepted start
//   busy   out  high while MUL/CMP are running
//   done   out  one-cycle pulse, high while in FIN
//   t      out  5-bit result (0 when not found), held until the next FIN
//   found  out  1 when t is a valid match
//
// Handshake: start is a request with no ready; it is accepted only when
// busy=0 and done=0 (IDLE). Requests at any other time are dropped.
module best_t (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [12:0] n,
  input  logic [3:0]  u,
  output logic        busy,
  output logic        done,
  output logic [4:0]  t,
  output logic        found
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_CMP  = 2'd2,
    S_FIN  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [12:0] n_q, n_d;
  logic [3:0]  u_q, u_d;
  logic [4:0]  cand_q, cand_d;
  logic [17:0] acc_q, acc_d;
  logic [2:0]  bit_q, bit_d;
  logic [4:0]  t_q, t_d;
  logic        found_q, found_d;

  logic [4:0]  theta;
  logic [12:0] q_val;
  logic [3:0]  u_of_q;
  logic [17:0] n_ext;

  // theta(t): multiplier applied to n for the current candidate.
  always_comb begin
    theta = 5'd1;
    if      (cand_q >= 5'd11) theta = 5'd1;
    else if (cand_q >= 5'd8)  theta = 5'd2;
    else if (cand_q >= 5'd6)  theta = 5'd3;
    else if (cand_q == 5'd5)  theta = 5'd4;
    else if (cand_q == 5'd4)  theta = 5'd5;
    else if (cand_q == 5'd3)  theta = 5'd6;
    else if (cand_q == 5'd2)  theta = 5'd9;
    else                      theta = 5'd16;
  end

  // u_of(q): strict thresholds at powers of two from 1 to 2048.
  assign q_val = acc_q[17:5];
  always_comb begin
    u_of_q = 4'd0;
    if      (q_val > 13'd2048) u_of_q = 4'd12;
    else if (q_val > 13'd1024) u_of_q = 4'd11;
    else if (q_val > 13'd512)  u_of_q = 4'd10;
    else if (q_val > 13'd256)  u_of_q = 4'd9;
    else if (q_val > 13'd128)  u_of_q = 4'd8;
    else if (q_val > 13'd64)   u_of_q = 4'd7;
    else if (q_val > 13'd32)   u_of_q = 4'd6;
    else if (q_val > 13'd16)   u_of_q = 4'd5;
    else if (q_val > 13'd8)    u_of_q = 4'd4;
    else if (q_val > 13'd4)    u_of_q = 4'd3;
    else if (q_val > 13'd2)    u_of_q = 4'd2;
    else if (q_val > 13'd1)    u_of_q = 4'd1;
  end

  assign n_ext = {5'd0, n_q};

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    u_d     = u_q;
    cand_d  = cand_q;
    acc_d   = acc_q;
    bit_d   = bit_q;
    t_d     = t_q;
    found_d = found_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d     = n;
          u_d     = u;
          cand_d  = 5'd1;
          acc_d   = 18'd0;
          bit_d   = 3'd0;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        // One theta bit per cycle, LSB first; bit 4 is the last step.
        if (theta[bit_q]) acc_d = acc_q + (n_ext << bit_q);
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd4) state_d = S_CMP;
      end
      S_CMP: begin
        if (u_of_q <= u_q) begin
          found_d = 1'b1;
          t_d     = cand_q;
          state_d = S_FIN;
        end else if (cand_q == 5'd18) begin
          found_d = 1'b0;
          t_d     = 5'd0;
          state_d = S_FIN;
        end else begin
          cand_d  = cand_q + 5'd1;
          acc_d   = 18'd0;
          bit_d   = 3'd0;
          state_d = S_MUL;
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      n_q     <= 13'd0;
      u_q     <= 4'd0;
      cand_q  <= 5'd0;
      acc_q   <= 18'd0;
      bit_q   <= 3'd0;
      t_q     <= 5'd0;
      found_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      u_q     <= u_d;
      cand_q  <= cand_d;
      acc_q   <= acc_d;
      bit_q   <= bit_d;
      t_q     <= t_d;
      found_q <= found_d;
    end
  end

  // busy/done decode straight from the state register, so both change on
  // the edge that enters FIN.
  assign busy  = (state_q == S_MUL) || (state_q == S_CMP);
  assign done  = (state_q == S_FIN);
  assign t     = t_q;
  assign found = found_q;

endmodule

// File: tb/tb_best_t.sv
module tb_best_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [12:0] n_in;
  logic [3:0]  u_in;
  logic        busy;
  logic        done;
  logic [4:0]  t;
  logic        found;

  int checks;
  int errors;
  int prev_t;
  int prev_f;

  best_t dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .n     (n_in),
    .u     (u_in),
    .busy  (busy),
    .done  (done),
    .t     (t),
    .found (found)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one request and follow it to done. Edge 0 is the edge that samples
  // start. inj_edge >= 0 pulses start (with different n/u that stay applied)
  // right after that edge to show it is ignored.
  task automatic run_search(input string tag, input int nv, input int uv,
                            input int exp_t, input int exp_f,
                            input int exp_edge, input int inj_edge);
    int done_edge;
    int busy_cnt;
    done_edge = -1;
    busy_cnt  = 0;
    @(negedge clk);
    n_in  = 13'(nv);
    u_in  = 4'(uv);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "_hold_t"}, int'(t), prev_t);
    check({tag, "_hold_found"}, int'(found), prev_f);
    for (int e = 0; e <= 150; e++) begin
      if (e > 0) begin
        @(posedge clk);
        #1;
        start = 1'b0;
      end
      if (done) begin
        done_edge = e;
        break;
      end
      if (busy) busy_cnt++;
      if (e == inj_edge) begin
        start = 1'b1;
        n_in  = 13'd32;
        u_in  = 4'd0;
      end
    end
    check({tag, "_done_edge"}, done_edge, exp_edge);
    check({tag, "_busy_cycles"}, busy_cnt, exp_edge);
    check({tag, "_busy_at_done"}, int'(busy), 0);
    check({tag, "_t"}, int'(t), exp_t);
    check({tag, "_found"}, int'(found), exp_f);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, int'(done), 0);
    check({tag, "_t_held"}, int'(t), exp_t);
    prev_t = exp_t;
    prev_f = exp_f;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    prev_t = 0;
    prev_f = 0;
    start  = 1'b0;
    n_in   = 13'd0;
    u_in   = 4'd0;
    rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_t", int'(t), 0);
    check("reset_found", int'(found), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Immediately after reset release: first start accepted.
    run_search("u12", 4900, 12, 1, 1, 6, -1);
    run_search("u9", 4900, 9, 6, 1, 36, -1);
    run_search("u8", 4900, 8, 11, 1, 66, -1);
    run_search("n32u0", 32, 0, 11, 1, 66, -1);
    run_search("u7", 4900, 7, 0, 0, 108, -1);
    run_search("u15", 100, 15, 1, 1, 6, -1);
    // Start pulse at edge 10 with n/u changed: original search unaffected.
    run_search("inject", 4900, 9, 6, 1, 36, 10);

    // Reset at edge 20 of a search: outputs clear at once, no done.
    @(negedge clk);
    n_in  = 13'd4900;
    u_in  = 4'd8;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("mid_busy_before_rst", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("rst_async_busy", int'(busy), 0);
    check("rst_async_done", int'(done), 0);
    check("rst_async_t", int'(t), 0);
    check("rst_async_found", int'(found), 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("rst_no_done", int'(done), 0);
    end
    @(negedge clk);
    rst_n  = 1'b1;
    prev_t = 0;
    prev_f = 0;
    run_search("after_rst", 4900, 12, 1, 1, 6, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
